pipeline_drain: RTL and testbench
=================================

Name: pipeline_drain

Overview:
- Receive side for tagged pipeline outputs. Sits at the output of a pipeline whose valid pulse means "transfer now": any cycle with valid_in high is a completed transfer.
- Buffers {tag, data} results in a small FIFO and re-presents them to a consumer with a persistent valid/ready handshake.
- Drives ready_out back into the producing pipeline's ready input, so the pipeline stalls instead of losing results.

Parameters:
TAG_WIDTH, 32, width of tag field
DATA_WIDTH, 32, width of result payload
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_WIDTH, 3, occupancy counter width; must equal log2(DEPTH)+1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_in  in  1  upstream result valid; high = transfer this cycle
tag_in  in  TAG_WIDTH  upstream tag
data_in  in  DATA_WIDTH  upstream payload
ready_out  out  1  to producer's ready input; drain can accept this cycle
valid_out  out  1  head entry valid; held until accepted
ready_in  in  1  consumer accepts head this cycle
tag_out  out  TAG_WIDTH  head tag
data_out  out  DATA_WIDTH  head payload
count  out  CNT_WIDTH  current occupancy, 0..DEPTH
busy  out  1  count != 0
overflow  out  1  sticky: a push was attempted while not ready

Behaviour:
- Reset (async, immediate effect): rd_ptr=0, wr_ptr=0, count=0, overflow=0, valid_out=0, busy=0. tag_out/data_out are 0 while empty. Storage array is not reset.
- pop = valid_out & ready_in.
- ready_out = (count != DEPTH) | pop. This is combinational from ready_in, so a full FIFO with a same-cycle pop still accepts.
- push = valid_in & ready_out.
- Push: write {tag_in, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: rd_ptr advances modulo DEPTH.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, including at full and at count=1
- Empty + push: the entry appears on valid_out the next cycle (1-cycle latency, non-bypass build).
- Empty + push + ready_in in the same cycle: no pop (valid_out is 0 that cycle).
- valid_out = (count != 0). tag_out/data_out = storage[rd_ptr], and stay stable while valid_out is high and ready_in is low.
- Ordering: strict FIFO. Tags are never reordered or modified.
- Overflow: valid_in high while ready_out low.
  - The entry is dropped.
  - overflow sets on the next edge and stays set until reset.
  - count and pointers are unchanged.
- ready_in while empty: ignored, no state change.
- Reset mid-operation: all contents are discarded and outputs return to reset values asynchronously.
- No internal FSM beyond the pointers and counter. States are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all derived from count.

Optional Feature:
- Macro: PIPELINE_DRAIN_BYPASS_EN.
- Defined, FIFO empty and valid_in high:
  - valid_out is asserted combinationally in the same cycle.
  - tag_out/data_out are driven directly from tag_in/data_in.
  - If ready_in is also high, the entry is consumed in that cycle and never written; count stays 0.
  - If ready_in is low, the entry is written normally.
- Undefined: 1-cycle minimum latency, with no combinational path from valid_in/tag_in/data_in to the outputs.

Test Plan:
- Reset then idle, ready_in=1 -> valid_out=0, count=0, ready_out=1, overflow=0, busy=0.
- Push tags 1,2,3,4 with data 0xA..0xD, ready_in=0 -> count=4, ready_out=0. Then raise ready_in -> tags 1,2,3,4 pop in order on consecutive cycles, count returns to 0.
- Full (DEPTH=4), ready_in=1, valid_in=1 tag=5 in the same cycle -> ready_out=1, tag 1 pops, tag 5 is stored, count stays 4, no overflow.
- Full, ready_in=0, valid_in=1 tag=9 -> overflow=1 next cycle and stays 1. Tag 9 never appears on tag_out; count stays 4.
- Continuous push and pop of tags 0..15 with ready_in=1 -> every tag output exactly once in order, pointers wrap, count never exceeds 1 (0 with BYPASS_EN).
- With 2 entries stored, assert reset asynchronously mid-cycle -> valid_out=0 and count=0 immediately. After release, push tag 7 -> tag 7 is the next output.

Source files
------------

// File: rtl/pipeline_drain.sv
// pipeline_drain: receive-side drain FIFO for a tagged result pipeline.
// Incoming {tag, data} transfers (valid_in = transfer now) are buffered and
// re-presented to a consumer through a persistent valid/ready handshake.
// ready_out feeds the producer's ready input so results are never lost
// while the producer honours it; ignored backpressure sets sticky overflow.
// Optional build macro: PIPELINE_DRAIN_BYPASS_EN (empty-FIFO cut-through).
module pipeline_drain #(
   parameter int unsigned TAG_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [TAG_WIDTH-1:0]  tag_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  busy,
   output logic                  overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = TAG_WIDTH + DATA_WIDTH;

   // Fill level is a pure function of the occupancy counter.
   typedef enum logic [1:0] {
      FILL_EMPTY,
      FILL_PARTIAL,
      FILL_FULL
   } fill_e;

   logic [ENT_W-1:0]     storage [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 overflow_q;
   fill_e                fill;
   logic [ENT_W-1:0]     head;
   logic                 pop;
   logic                 push;
   logic                 bypass_take;
   logic                 wr_en;
   logic                 rd_en;

   // Classify occupancy into empty / partial / full.
   always_comb begin
      fill = FILL_PARTIAL;
      if (count_q == '0) begin
         fill = FILL_EMPTY;
      end else if (count_q == CNT_WIDTH'(DEPTH)) begin
         fill = FILL_FULL;
      end
   end

   // Handshake decode: head presentation, pop/push qualification, ready_out.
   always_comb begin
      head        = storage[rd_ptr];
      valid_out   = 1'b0;
      tag_out     = '0;
      data_out    = '0;
      bypass_take = 1'b0;

      if (fill != FILL_EMPTY) begin
         valid_out = 1'b1;
         tag_out   = head[ENT_W-1:DATA_WIDTH];
         data_out  = head[DATA_WIDTH-1:0];
      end
`ifdef PIPELINE_DRAIN_BYPASS_EN
      else if (valid_in) begin
         valid_out = 1'b1;
         tag_out   = tag_in;
         data_out  = data_in;
      end
`endif

      pop       = valid_out & ready_in;
      // A pop frees a slot this cycle, so a full FIFO still accepts.
      ready_out = (fill != FILL_FULL) | pop;
      push      = valid_in & ready_out;

`ifdef PIPELINE_DRAIN_BYPASS_EN
      // Empty cut-through consumed this cycle: never touches storage.
      bypass_take = (fill == FILL_EMPTY) & pop;
`endif

      wr_en = push & ~bypass_take;
      rd_en = pop & ~bypass_take;
   end

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CNT_WIDTH'(1);
            2'b01:   count_q <= count_q - CNT_WIDTH'(1);
            default: count_q <= count_q;
         endcase
         if (valid_in & ~ready_out) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         storage[wr_ptr] <= {tag_in, data_in};
      end
   end

   // Status outputs.
   always_comb begin
      count    = count_q;
      busy     = (fill != FILL_EMPTY);
      overflow = overflow_q;
   end

endmodule

// File: tb/tb_pipeline_drain.sv
// tb_pipeline_drain: self-checking bench for pipeline_drain.
// A queue-based model predicts every output at each negative clock edge;
// directed sequences add literal expectations, followed by a random phase.
// Honours PIPELINE_DRAIN_BYPASS_EN when the DUT is built with it.
module tb_pipeline_drain;

   localparam int unsigned TW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in;
   logic [TW-1:0] tag_in;
   logic [DW-1:0] data_in;
   logic          ready_out;
   logic          valid_out;
   logic          ready_in;
   logic [TW-1:0] tag_out;
   logic [DW-1:0] data_out;
   logic [CW-1:0] count;
   logic          busy;
   logic          overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: queued {tag,data} entries and sticky overflow.
   logic [TW+DW-1:0] mq[$];
   logic             m_ovf = 1'b0;

`ifdef PIPELINE_DRAIN_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   pipeline_drain #(
      .TAG_WIDTH (TW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .CNT_WIDTH (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_in (valid_in),
      .tag_in   (tag_in),
      .data_in  (data_in),
      .ready_out(ready_out),
      .valid_out(valid_out),
      .ready_in (ready_in),
      .tag_out  (tag_out),
      .data_out (data_out),
      .count    (count),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model compare and update at each negedge (inputs stable until posedge).
   always @(negedge clk) begin
      if (!reset) begin
         logic             e_valid;
         logic             e_ready;
         logic [TW+DW-1:0] e_head;
         logic             m_pop;
         logic             m_push;
         int               sz;
         sz      = mq.size();
         e_valid = (sz != 0) || (BYPASS && valid_in);
         if (sz != 0)                  e_head = mq[0];
         else if (BYPASS && valid_in)  e_head = {tag_in, data_in};
         else                          e_head = '0;
         e_ready = (sz != DEPTH) || (e_valid && ready_in);

         chk("m_valid_out", 64'(valid_out), 64'(e_valid));
         chk("m_ready_out", 64'(ready_out), 64'(e_ready));
         chk("m_tag_out",   64'(tag_out),   64'(e_head[TW+DW-1:DW]));
         chk("m_data_out",  64'(data_out),  64'(e_head[DW-1:0]));
         chk("m_count",     64'(count),     64'(sz));
         chk("m_busy",      64'(busy),      64'(sz != 0));
         chk("m_overflow",  64'(overflow),  64'(m_ovf));

         m_pop  = e_valid && ready_in;
         m_push = valid_in && e_ready;
         if (valid_in && !e_ready) m_ovf = 1'b1;
         if (!(sz == 0 && m_pop)) begin
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back({tag_in, data_in});
         end
      end
   end

   // One clock cycle with the given inputs; returns 1 time unit after the edge.
   task automatic drive(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                        input logic r);
      valid_in = v;
      tag_in   = t;
      data_in  = d;
      ready_in = r;
      @(posedge clk);
      #1;
   endtask

   task automatic fill4(input logic [TW-1:0] base);
      for (int unsigned k = 0; k < 4; k++) begin
         drive(1'b1, base + TW'(k), DW'(32'hA) + DW'(k), 1'b0);
      end
   endtask

   initial begin
      logic [TW-1:0] exp_tags[4];
      int            max_cnt;

      reset    = 1'b1;
      valid_in = 1'b0;
      tag_in   = '0;
      data_in  = '0;
      ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset then idle with ready_in high.
      drive(1'b0, '0, '0, 1'b1);
      chk("idle_valid_out", 64'(valid_out), 64'd0);
      chk("idle_count",     64'(count),     64'd0);
      chk("idle_ready_out", 64'(ready_out), 64'd1);
      chk("idle_overflow",  64'(overflow),  64'd0);
      chk("idle_busy",      64'(busy),      64'd0);

      // Fill with tags 1..4, data 0xA..0xD, consumer stalled.
      fill4(32'd1);
      valid_in = 1'b0;
      #1;
      chk("full_count",     64'(count),     64'd4);
      chk("full_ready_out", 64'(ready_out), 64'd0);

      // Drain in order.
      for (int unsigned k = 1; k <= 4; k++) begin
         valid_in = 1'b0;
         ready_in = 1'b1;
         #1;
         chk("drain_tag",  64'(tag_out),  64'(k));
         chk("drain_data", 64'(data_out), 64'(32'h9 + k));
         @(posedge clk);
         #1;
      end
      chk("drain_count", 64'(count), 64'd0);

      // Full with simultaneous pop and push of tag 5.
      fill4(32'd1);
      valid_in = 1'b1;
      tag_in   = 32'd5;
      data_in  = 32'h55;
      ready_in = 1'b1;
      #1;
      chk("fullpp_ready_out", 64'(ready_out), 64'd1);
      chk("fullpp_tag_out",   64'(tag_out),   64'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      ready_in = 1'b0;
      #1;
      chk("fullpp_count",    64'(count),    64'd4);
      chk("fullpp_overflow", 64'(overflow), 64'd0);
      exp_tags = '{32'd2, 32'd3, 32'd4, 32'd5};
      for (int unsigned k = 0; k < 4; k++) begin
         ready_in = 1'b1;
         #1;
         chk("fullpp_order", 64'(tag_out), 64'(exp_tags[k]));
         @(posedge clk);
         #1;
      end

      // Overflow: full, stalled consumer, tag 9 offered.
      fill4(32'd20);
      valid_in = 1'b1;
      tag_in   = 32'd9;
      data_in  = 32'h99;
      ready_in = 1'b0;
      #1;
      chk("ovf_ready_out", 64'(ready_out), 64'd0);
      @(posedge clk);
      #1;
      chk("ovf_set",   64'(overflow), 64'd1);
      chk("ovf_count", 64'(count),    64'd4);
      drive(1'b0, '0, '0, 1'b0);
      chk("ovf_sticky", 64'(overflow), 64'd1);
      for (int unsigned k = 0; k < 4; k++) begin
         valid_in = 1'b0;
         ready_in = 1'b1;
         #1;
         chk("ovf_order", 64'(tag_out), 64'(32'd20 + k));
         @(posedge clk);
         #1;
      end
      chk("ovf_still_set", 64'(overflow), 64'd1);

      // Continuous streaming of tags 0..15, pointers wrap several times.
      max_cnt = 0;
      for (int unsigned k = 0; k < 16; k++) begin
         drive(1'b1, TW'(k), DW'(k * 3), 1'b1);
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      drive(1'b0, '0, '0, 1'b1);
      drive(1'b0, '0, '0, 1'b1);
      chk("stream_max_count", 64'(max_cnt), BYPASS ? 64'd0 : 64'd1);
      chk("stream_end_count", 64'(count), 64'd0);

      // Asynchronous reset with two entries stored.
      drive(1'b1, 32'd40, 32'h40, 1'b0);
      drive(1'b1, 32'd41, 32'h41, 1'b0);
      valid_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_valid_out", 64'(valid_out), 64'd0);
      chk("arst_count",     64'(count),     64'd0);
      chk("arst_overflow",  64'(overflow),  64'd0);
      mq.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      drive(1'b1, 32'd7, 32'h77, 1'b0);
      valid_in = 1'b0;
      #1;
      chk("arst_next_tag", 64'(tag_out), 64'd7);
      chk("arst_next_cnt", 64'(count),   64'd1);

      // Random traffic against the model.
      for (int unsigned k = 0; k < 500; k++) begin
         drive(($urandom_range(0, 9) < 6), TW'($urandom), DW'($urandom),
               ($urandom_range(0, 1) == 1));
      end
      drive(1'b0, '0, '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
